alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Hardwired control sequencer for the 32-bit datapath. It generates the T0..T5 control strobes that
//  fetch one instruction and execute a register-register ALU op (add/sub/shr/shl/ror/rol/and/or).
//  It replaces hand-driven control strobes: it sits between the IR/memory interface and the datapath
//  control inputs, with a memory-ready handshake, a read timeout, illegal-opcode detection and a free-run mode.
// PARAMETERS
//  NUM_REGS     16  general registers; width of the one-hot reg_in/reg_out buses (<=16)
//  OPCODE_W      5  opcode field width, ir[31:27]
//  MEM_TIMEOUT  15  max T1 cycles waiting for mem_ready before bus_err (>=1)
// PORTS
//  Clock      in   1         single clock; all state changes on rising edge
//  Reset_n    in   1         asynchronous, active-low reset
//  start      in   1         begin one instruction from IDLE (ignored when not in IDLE)
//  run        in   1         1 = after T5 go straight to T0 (free-run); 0 = return to IDLE
//  mem_ready  in   1         memory read data valid on Mdatain this cycle
//  ir         in   32        IR register contents (fields: op[31:27] Ra[26:23] Rb[22:19] Rc[18:15])
//  PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read  out 1 each  datapath strobes
//  reg_in     out  NUM_REGS  one-hot register write enable (Ra)
//  reg_out    out  NUM_REGS  one-hot register bus drive (Rb or Rc)
//  alu_sel    out  8         one-hot ALU op {or,and,rol,ror,shl,shr,sub,add}; valid only in T4
//  busy       out  1         1 in any state other than IDLE
//  done       out  1         1-cycle pulse in T5
//  illegal    out  1         1-cycle pulse: bad opcode or register index >= NUM_REGS
//  bus_err    out  1         1-cycle pulse: mem_ready timeout
// BEHAVIOUR
//  - Reset (async, Reset_n=0): state=IDLE; every output 0; timeout counter 0. Also applies mid-instruction.
//  - Outputs are a Moore decode of the registered state (plus ir in T3..T5). All strobes not listed for a state are 0.
//  - IDLE: start=1 -> T0.
//  - T0: PCout, MARin, IncPC, Zin -> T1.
//  - T1: Zlowout, PCin, Read, MDRin. PCin only in the first T1 cycle; Read/MDRin are held until mem_ready=1 -> T2.
//        The counter increments each wait cycle; if count==MEM_TIMEOUT and mem_ready=0 -> IDLE with bus_err pulse.
//  - T2: MDRout, IRin (IR loads at the end of T2) -> T3.
//  - T3: decode ir. Legal = op in 00011..01010 and Ra,Rb,Rc < NUM_REGS.
//        Illegal -> IDLE with illegal pulse, no strobes this cycle. Legal -> reg_out[Rb], Yin -> T4.
//  - T4: reg_out[Rc], Zin, alu_sel = onehot(op-3) -> T5.
//  - T5: Zlowout, reg_in[Ra], done -> T0 if run=1, else IDLE.
//  - Opcodes: add=00011 sub=00100 shr=00101 shl=00110 ror=00111 rol=01000 and=01001 or=01010.
//  - Latency: 6 cycles per instruction with mem_ready=1 in T1, plus 1 cycle per wait cycle.
//  - Ra==Rb==Rc is legal (reads complete before the T5 write).
//  - R0 is writable.
//  - start during busy: ignored.
//  - run sampled only in T5.
//  - mem_ready outside T1: ignored.
//  - reg_in/reg_out are never both nonzero in one cycle.
//  - At most one of done/illegal/bus_err per cycle.
// STRUCTURE
//  - Package alu_seq_pkg: state enum {IDLE,T0..T5}, opcode localparams, IR field bit positions, ALU one-hot index constants.
//  - Sub-module reg_sel_decoder: (4-bit field, enable) -> NUM_REGS one-hot, plus an out_of_range flag.
//    Instantiated twice: write (Ra) and read (Rb/Rc muxed by state).
//  - Timeout counter width is $clog2(MEM_TIMEOUT+1).
// TESTING
//  1. start, mem_ready=1, ir=0x4A920000 (and R5,R2,R4): T3 reg_out=0x0004,Yin; T4 reg_out=0x0010,alu_sel=0x40,Zin;
//     T5 reg_in=0x0020, done. 6 cycles start-to-done.
//  2. run=1, ir=0x18918000 (add R1,R2,R3): back-to-back instructions, done every 6 cycles,
//     alu_sel=0x01, reg_in=0x0002; busy stays 1.
//  3. mem_ready low for 3 T1 cycles: Read/MDRin held 4 cycles, PCin only in the first; done at cycle 9.
//  4. mem_ready never asserted: bus_err pulses after MEM_TIMEOUT T1 cycles; state IDLE; no IRin seen.
//  5. ir=0x00000000 (ld) and NUM_REGS=8 with Ra=9: illegal pulse in T3, no Yin/reg_out, back in IDLE.
//  6. Reset_n low during T4: all outputs 0 immediately (async); next start restarts at T0.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU op sequencer: state encoding,
// opcode values, IR field positions and ALU one-hot bit indices.
package alu_seq_pkg;

    typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5} state_t;

    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_SUB = 5'b00100;
    localparam logic [4:0] OP_SHR = 5'b00101;
    localparam logic [4:0] OP_SHL = 5'b00110;
    localparam logic [4:0] OP_ROR = 5'b00111;
    localparam logic [4:0] OP_ROL = 5'b01000;
    localparam logic [4:0] OP_AND = 5'b01001;
    localparam logic [4:0] OP_OR  = 5'b01010;

    // IR field positions: op[31:27] Ra[26:23] Rb[22:19] Rc[18:15]
    localparam int OP_MSB    = 31;
    localparam int RA_LSB    = 23;
    localparam int RB_LSB    = 19;
    localparam int RC_LSB    = 15;
    localparam int REG_IDX_W = 4;

    // Bit positions inside alu_sel
    localparam int ALU_ADD = 0;
    localparam int ALU_SUB = 1;
    localparam int ALU_SHR = 2;
    localparam int ALU_SHL = 3;
    localparam int ALU_ROR = 4;
    localparam int ALU_ROL = 5;
    localparam int ALU_AND = 6;
    localparam int ALU_OR  = 7;

    // Only the register-register ALU ops are executed by this sequencer
    function automatic logic op_legal(input logic [4:0] op);
        return (op >= OP_ADD) && (op <= OP_OR);
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Bundle between the IR/memory side and the datapath control inputs.
// master drives start/run/mem_ready/ir; slave is the sequencer.
interface alu_op_sequencer_if #(parameter int NUM_REGS = 16);
    logic                start;
    logic                run;
    logic                mem_ready;
    logic [31:0]         ir;
    logic                PCout, Zlowout, MDRout, MARin, Zin, PCin;
    logic                MDRin, IRin, Yin, IncPC, Read;
    logic [NUM_REGS-1:0] reg_in;
    logic [NUM_REGS-1:0] reg_out;
    logic [7:0]          alu_sel;
    logic                busy, done, illegal, bus_err;

    modport master (
        output start, run, mem_ready, ir,
        input  PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read,
        input  reg_in, reg_out, alu_sel, busy, done, illegal, bus_err
    );

    modport slave (
        input  start, run, mem_ready, ir,
        output PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read,
        output reg_in, reg_out, alu_sel, busy, done, illegal, bus_err
    );
endinterface

// File: rtl/alu_op_sequencer_reg_sel_decoder.sv
// 4-bit register field to one-hot select. Indices beyond NUM_REGS decode to
// all-zero and raise out_of_range (independent of en, so callers can use it
// for legality checks without creating a feedback path through en).
module reg_sel_decoder
    import alu_seq_pkg::*;
#(
    parameter int NUM_REGS = 16
) (
    input  logic [REG_IDX_W-1:0] idx,
    input  logic                 en,
    output logic [NUM_REGS-1:0]  onehot,
    output logic                 out_of_range
);

    // Range flag and one-hot expansion
    always_comb begin
        out_of_range = (32'(idx) >= NUM_REGS);
        onehot       = '0;
        for (int i = 0; i < NUM_REGS; i++)
            onehot[i] = en && (idx == REG_IDX_W'(i));
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Hardwired T0..T5 control sequencer: fetch one instruction over a
// mem_ready handshake, then execute a register-register ALU op.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int NUM_REGS    = 16,
    parameter int OPCODE_W    = 5,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                Clock,
    input  logic                Reset_n,
    alu_op_sequencer_if.slave   bus
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    state_t                state, next;
    logic [CW-1:0]         count;
    logic                  bus_err_q;
    logic                  timeout_hit;
    logic [OPCODE_W-1:0]   op;
    logic [REG_IDX_W-1:0]  ra, rb, rc, rd_idx;
    logic                  ra_oor, rd_oor, rc_oor, legal;
    logic [NUM_REGS-1:0]   wr_hot, rd_hot;
    logic                  unused_ir;

    assign op        = bus.ir[OP_MSB -: OPCODE_W];
    assign ra        = bus.ir[RA_LSB +: REG_IDX_W];
    assign rb        = bus.ir[RB_LSB +: REG_IDX_W];
    assign rc        = bus.ir[RC_LSB +: REG_IDX_W];
    assign unused_ir = ^bus.ir[RC_LSB-1:0];

    assign rc_oor      = (32'(rc) >= NUM_REGS);
    // rd_oor reflects Rb here because the read decoder selects Rb in T3
    assign legal       = op_legal(5'(op)) && !ra_oor && !rd_oor && !rc_oor;
    assign timeout_hit = !bus.mem_ready && (count == CW'(MEM_TIMEOUT));

    // Read port: Rb drives the bus in T3 (into Y), Rc in T4 (into the ALU)
    assign rd_idx = (state == T4) ? rc : rb;

    reg_sel_decoder #(.NUM_REGS(NUM_REGS)) u_wr_dec (
        .idx          (ra),
        .en           (state == T5),
        .onehot       (wr_hot),
        .out_of_range (ra_oor)
    );

    reg_sel_decoder #(.NUM_REGS(NUM_REGS)) u_rd_dec (
        .idx          (rd_idx),
        .en           ((state == T3) || (state == T4)),
        .onehot       (rd_hot),
        .out_of_range (rd_oor)
    );

    assign bus.reg_in  = wr_hot;
    assign bus.reg_out = (state == T3 && !legal) ? '0 : rd_hot;
    assign bus.busy    = (state != IDLE);
    assign bus.bus_err = bus_err_q;

    // State register
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= next;
    end

    // T1 wait counter; cleared whenever we are not waiting in T1
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n)
            count <= '0;
        else if (state == T1 && !bus.mem_ready && count != CW'(MEM_TIMEOUT))
            count <= count + 1'b1;
        else
            count <= '0;
    end

    // bus_err is a registered pulse, seen in the IDLE cycle after the abort
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) bus_err_q <= 1'b0;
        else          bus_err_q <= (state == T1) && timeout_hit;
    end

    // Next-state and strobe decode
    always_comb begin
        next        = state;
        bus.PCout   = 1'b0;
        bus.Zlowout = 1'b0;
        bus.MDRout  = 1'b0;
        bus.MARin   = 1'b0;
        bus.Zin     = 1'b0;
        bus.PCin    = 1'b0;
        bus.MDRin   = 1'b0;
        bus.IRin    = 1'b0;
        bus.Yin     = 1'b0;
        bus.IncPC   = 1'b0;
        bus.Read    = 1'b0;
        bus.alu_sel = '0;
        bus.done    = 1'b0;
        bus.illegal = 1'b0;
        unique case (state)
            IDLE: if (bus.start) next = T0;
            T0: begin
                bus.PCout = 1'b1;
                bus.MARin = 1'b1;
                bus.IncPC = 1'b1;
                bus.Zin   = 1'b1;
                next      = T1;
            end
            T1: begin
                bus.Zlowout = 1'b1;
                bus.Read    = 1'b1;
                bus.MDRin   = 1'b1;
                // PC is written back once; later wait cycles only hold the read
                bus.PCin    = (count == '0);
                if (bus.mem_ready)  next = T2;
                else if (timeout_hit) next = IDLE;
            end
            T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
                next       = T3;
            end
            T3: begin
                if (legal) begin
                    bus.Yin = 1'b1;
                    next    = T4;
                end else begin
                    bus.illegal = 1'b1;
                    next        = IDLE;
                end
            end
            T4: begin
                bus.Zin     = 1'b1;
                bus.alu_sel = 8'b1 << 3'(5'(op) - OP_ADD);
                next        = T5;
            end
            T5: begin
                bus.Zlowout = 1'b1;
                bus.done    = 1'b1;
                next        = bus.run ? T0 : IDLE;
            end
            default: next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized bench: each instruction is expanded into the expected
// cycle-by-cycle strobe trace from the sequencing rules, then replayed
// against the sequencer and compared every cycle.
module tb_alu_op_sequencer;

    localparam int NR = 8;
    localparam int TO = 5;

    logic Clock = 1'b0;
    logic Reset_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    always #5 Clock = ~Clock;

    alu_op_sequencer_if #(.NUM_REGS(NR)) bus ();

    alu_op_sequencer #(.NUM_REGS(NR), .OPCODE_W(5), .MEM_TIMEOUT(TO)) dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    typedef struct packed {
        logic PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read;
        logic [NR-1:0] reg_in;
        logic [NR-1:0] reg_out;
        logic [7:0]    alu_sel;
        logic busy, done, illegal, bus_err;
    } obs_t;

    typedef struct {
        logic        start, run, mr;
        logic [31:0] ir;
        obs_t        o;
    } cyc_t;

    cyc_t q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic obs_t observe();
        obs_t o;
        o.PCout = bus.PCout;   o.Zlowout = bus.Zlowout; o.MDRout = bus.MDRout;
        o.MARin = bus.MARin;   o.Zin = bus.Zin;         o.PCin = bus.PCin;
        o.MDRin = bus.MDRin;   o.IRin = bus.IRin;       o.Yin = bus.Yin;
        o.IncPC = bus.IncPC;   o.Read = bus.Read;
        o.reg_in = bus.reg_in; o.reg_out = bus.reg_out; o.alu_sel = bus.alu_sel;
        o.busy = bus.busy;     o.done = bus.done;
        o.illegal = bus.illegal; o.bus_err = bus.bus_err;
        return o;
    endfunction

    // One cycle with don't-care inputs randomized; start only toggles while
    // busy (where it must be ignored), never in an idle cycle.
    function automatic cyc_t mk(input logic [31:0] ir, input logic busy);
        cyc_t c;
        c.start  = busy ? 1'($urandom) : 1'b0;
        c.run    = 1'($urandom);
        c.mr     = 1'($urandom);
        c.ir     = ir;
        c.o      = '0;
        c.o.busy = busy;
        return c;
    endfunction

    // Expected trace for one instruction. waits = mem_ready-low cycles in T1
    // (more than TO means the read times out).
    task automatic add_instr(input logic [31:0] ir, input int waits, input logic runf,
                             input logic chained, output logic chain_out);
        cyc_t c;
        int op, ra, rb, rc, n;
        logic legal, tmo;
        op = int'(ir[31:27]); ra = int'(ir[26:23]);
        rb = int'(ir[22:19]); rc = int'(ir[18:15]);
        legal = (op >= 3) && (op <= 10) && (ra < NR) && (rb < NR) && (rc < NR);
        tmo   = (waits > TO);
        chain_out = 1'b0;
        if (!chained) begin
            c = mk(ir, 1'b0); c.start = 1'b1; q.push_back(c);
        end
        c = mk(ir, 1'b1);
        c.o.PCout = 1'b1; c.o.MARin = 1'b1; c.o.IncPC = 1'b1; c.o.Zin = 1'b1;
        q.push_back(c);
        n = tmo ? TO + 1 : waits + 1;
        for (int i = 0; i < n; i++) begin
            c = mk(ir, 1'b1);
            c.mr = !tmo && (i == n - 1);
            c.o.Zlowout = 1'b1; c.o.Read = 1'b1; c.o.MDRin = 1'b1;
            c.o.PCin = (i == 0);
            q.push_back(c);
        end
        if (tmo) begin
            c = mk(ir, 1'b0); c.o.bus_err = 1'b1; q.push_back(c);
            return;
        end
        c = mk(ir, 1'b1); c.o.MDRout = 1'b1; c.o.IRin = 1'b1; q.push_back(c);
        c = mk(ir, 1'b1);
        if (!legal) begin
            c.o.illegal = 1'b1; q.push_back(c);
            return;
        end
        c.o.Yin = 1'b1; c.o.reg_out[rb] = 1'b1; q.push_back(c);
        c = mk(ir, 1'b1);
        c.o.Zin = 1'b1; c.o.reg_out[rc] = 1'b1; c.o.alu_sel[op-3] = 1'b1;
        q.push_back(c);
        c = mk(ir, 1'b1);
        c.o.Zlowout = 1'b1; c.o.done = 1'b1; c.o.reg_in[ra] = 1'b1; c.run = runf;
        q.push_back(c);
        chain_out = runf;
    endtask

    // Replay queued cycles: drive just after the rising edge, sample at the falling edge
    task automatic play();
        cyc_t c;
        while (q.size() > 0) begin
            c = q.pop_front();
            bus.start = c.start; bus.run = c.run; bus.mem_ready = c.mr; bus.ir = c.ir;
            @(negedge Clock);
            chk($sformatf("cyc%0d", cyc), 64'(observe()), 64'(c.o));
            cyc++;
            @(posedge Clock); #1;
        end
    endtask

    task automatic idle_check(input string tag);
        bus.start = 1'b0; bus.mem_ready = 1'($urandom); bus.run = 1'($urandom);
        @(negedge Clock);
        chk(tag, 64'(observe()), 64'(obs_t'('0)));
        @(posedge Clock); #1;
    endtask

    initial begin
        logic ch;
        obs_t e;
        int op, waits;
        logic [31:0] ir;

        Reset_n = 1'b0;
        bus.start = 1'b0; bus.run = 1'b0; bus.mem_ready = 1'b0; bus.ir = '0;
        #1;
        chk("reset_state", 64'(observe()), 64'(obs_t'('0)));
        repeat (2) @(posedge Clock);
        @(negedge Clock); Reset_n = 1'b1;
        @(posedge Clock); #1;

        // and R5,R2,R4
        add_instr(32'h4A920000, 0, 1'b0, 1'b0, ch); play();
        // add R1,R2,R3 free-running three times
        add_instr(32'h18918000, 0, 1'b1, 1'b0, ch);
        add_instr(32'h18918000, 0, 1'b1, ch, ch);
        add_instr(32'h18918000, 0, 1'b0, ch, ch); play();
        // memory wait, exact-limit wait, timeout
        add_instr(32'h4A920000, 3, 1'b0, 1'b0, ch); play();
        add_instr(32'h20918000, TO, 1'b0, 1'b0, ch); play();
        add_instr(32'h4A920000, TO + 1, 1'b0, 1'b0, ch); play();
        // illegal opcode, Ra out of range, Ra==Rb==Rc on R0
        add_instr(32'h00000000, 0, 1'b0, 1'b0, ch); play();
        add_instr({5'd3, 4'd9, 4'd1, 4'd2, 15'd0}, 0, 1'b0, 1'b0, ch); play();
        add_instr({5'd10, 4'd0, 4'd0, 4'd0, 15'd0}, 1, 1'b0, 1'b0, ch); play();
        idle_check("idle_after_dir");

        // Asynchronous reset while in T4
        bus.ir = 32'h18918000; bus.run = 1'b0; bus.mem_ready = 1'b1; bus.start = 1'b1;
        @(posedge Clock); #1; bus.start = 1'b0;
        repeat (4) begin @(posedge Clock); #1; end
        @(negedge Clock);
        e = '0; e.busy = 1'b1; e.Zin = 1'b1; e.reg_out[3] = 1'b1; e.alu_sel[0] = 1'b1;
        chk("pre_reset_t4", 64'(observe()), 64'(e));
        Reset_n = 1'b0; #1;
        chk("async_reset", 64'(observe()), 64'(obs_t'('0)));
        @(posedge Clock); #1;
        Reset_n = 1'b1;
        add_instr(32'h18918000, 0, 1'b0, 1'b0, ch); play();

        // Random instruction stream
        ch = 1'b0;
        for (int k = 0; k < 50; k++) begin
            int r;
            op = ($urandom % 4 == 0) ? int'($urandom % 32) : 3 + int'($urandom % 8);
            ir[31:27] = 5'(op);
            ir[26:23] = ($urandom % 6 == 0) ? 4'($urandom) : 4'($urandom % NR);
            ir[22:19] = ($urandom % 6 == 0) ? 4'($urandom) : 4'($urandom % NR);
            ir[18:15] = ($urandom % 6 == 0) ? 4'($urandom) : 4'($urandom % NR);
            ir[14:0]  = 15'($urandom);
            r = int'($urandom % 10);
            if (r < 5)       waits = 0;
            else if (r < 8)  waits = 1 + int'($urandom % 3);
            else if (r == 8) waits = TO;
            else             waits = TO + 1;
            add_instr(ir, waits, (k == 49) ? 1'b0 : 1'($urandom), ch, ch);
            play();
        end
        idle_check("idle_final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
